// File: rtl/cic_interp_seq_if.sv
// Control/status bundle between the CIC interpolator sequencer and its datapath/host.
// The master side drives the requests and the upstream valid; the sequencer is the slave.
interface cic_interp_seq_if #(
  parameter int gp_rate_width = 8
);
  logic                     ena;
  logic [gp_rate_width-1:0] rate;
  logic                     start;
  logic                     stop;
  logic                     in_valid;
  logic                     in_ready;
  logic                     comb_ena;
  logic                     upsmp_sel;
  logic                     int_ena;
  logic                     out_valid;
  logic                     busy;
  logic                     underrun;
  logic [gp_rate_width-1:0] phase;

  modport master (
    output ena, rate, start, stop, in_valid,
    input  in_ready, comb_ena, upsmp_sel, int_ena, out_valid, busy, underrun, phase
  );

  modport slave (
    input  ena, rate, start, stop, in_valid,
    output in_ready, comb_ena, upsmp_sel, int_ena, out_valid, busy, underrun, phase
  );
endinterface

// File: rtl/cic_interp_seq.sv
// CIC interpolator sequencer: low-rate comb strobes, high-rate integrator strobes,
// zero-stuff select and fill/flush tracking for a qualified output-valid.
module cic_interp_seq #(
  parameter int gp_rate_width = 8,
  parameter int gp_latency    = 6,
  parameter int gp_cnt_width  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_an,
  cic_interp_seq_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  localparam logic [gp_cnt_width-1:0] cnt_last = gp_cnt_width'(gp_latency - 1);

  state_t                   state_reg, state_next;
  logic [gp_rate_width-1:0] phase_reg, phase_next;
  logic [gp_rate_width-1:0] rate_reg, rate_next;
  logic [gp_cnt_width-1:0]  cnt_reg, cnt_next;
  logic                     sel_reg, sel_next;
  logic                     underrun_reg, underrun_next;
  logic                     from_run_reg, from_run_next;
  logic                     busy_reg, busy_next;
  logic                     in_ready_c;
  logic                     comb_ena_c;

  assign in_ready_c = bus.ena && (state_reg == FILL || state_reg == RUN) && (phase_reg == '0);
  assign comb_ena_c = in_ready_c && bus.in_valid;

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      state_reg    <= IDLE;
      phase_reg    <= '0;
      rate_reg     <= '0;
      cnt_reg      <= '0;
      sel_reg      <= 1'b0;
      underrun_reg <= 1'b0;
      from_run_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      phase_reg    <= phase_next;
      rate_reg     <= rate_next;
      cnt_reg      <= cnt_next;
      sel_reg      <= sel_next;
      underrun_reg <= underrun_next;
      from_run_reg <= from_run_next;
      busy_reg     <= busy_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    phase_next    = phase_reg;
    rate_next     = rate_reg;
    cnt_next      = cnt_reg;
    underrun_next = underrun_reg;
    from_run_next = from_run_reg;
    sel_next      = sel_reg;

    if (bus.ena) begin
      // sel follows acceptance by exactly one enabled cycle
      sel_next = comb_ena_c;
      if (state_reg != IDLE) begin
        phase_next = (phase_reg == rate_reg - 1'b1) ? '0 : phase_reg + 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            rate_next     = (bus.rate == '0) ? gp_rate_width'(1) : bus.rate;
            phase_next    = '0;
            cnt_next      = '0;
            underrun_next = 1'b0;
            state_next    = FILL;
          end
        end
        FILL: begin
          if (bus.stop) begin
            state_next    = FLUSH;
            cnt_next      = '0;
            from_run_next = 1'b0;
          end else if (cnt_reg == cnt_last) begin
            state_next = RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        RUN: begin
          if (phase_reg == '0 && !bus.in_valid) begin
            underrun_next = 1'b1;
          end
          if (bus.stop) begin
            state_next    = FLUSH;
            cnt_next      = '0;
            from_run_next = 1'b1;
          end
        end
        FLUSH: begin
          if (cnt_reg == cnt_last) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    busy_next = (state_next != IDLE);
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.comb_ena  = comb_ena_c;
  assign bus.upsmp_sel = bus.ena && sel_reg;
  assign bus.int_ena   = bus.ena && (state_reg != IDLE);
  assign bus.out_valid = bus.ena && ((state_reg == RUN) || (state_reg == FLUSH && from_run_reg));
  assign bus.busy      = busy_reg;
  assign bus.underrun  = underrun_reg;
  assign bus.phase     = phase_reg;
endmodule
